mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 resetn  in  1  reset, asynchronous, active-low.
REQ-003 in_valid  in  1  memory-stage instruction present; fields below stable while stall=1.
REQ-004 mem_read / mem_write  in  1 each  load / store request; both high is illegal and treated as store.
REQ-005 msize  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
REQ-006 sign_ext  in  1  load result sign-extended (1) or zero-extended (0).
REQ-007 addr  in  64  byte address; wdata  in  64  store data, right-aligned.
REQ-008 dreq_valid  out  1; dreq_addr  out  64; dreq_size  out  3; dreq_strobe  out  8; dreq_data  out  64: data-bus request.
REQ-009 dresp_addr_ok  in  1; dresp_data_ok  in  1; dresp_data  in  64: data-bus response.
REQ-010 stall  out  1  memory stage must hold; done  out  1  access complete this cycle; rdata  out  64  extended load result.
REQ-011 misalign  out  1  misaligned access flag (present only with MEM_MISALIGN_CHECK_EN).

Function
REQ-012 FSM states IDLE, REQ, WAIT, DONE; only memory ops (in_valid & (mem_read|mem_write)) leave IDLE.
REQ-013 IDLE: on a memory op, latch addr, size, strobe, shifted data and extension control, then go to REQ next edge.
REQ-014 REQ: dreq_valid=1 with all dreq_* fields stable; addr_ok&data_ok -> DONE; addr_ok only -> WAIT; neither -> stay.
REQ-015 WAIT: dreq_valid=0; data_ok -> DONE; dresp_data_ok during IDLE or REQ without addr_ok is ignored.
REQ-016 DONE: done=1 for exactly one cycle, rdata valid, next state IDLE unconditionally.
REQ-017 stall = memory op & state!=DONE; stall=0 for non-memory or invalid instructions.
REQ-018 Minimum latency: op seen in cycle 0, request in cycle 1, done in cycle 2; each extra addr_ok/data_ok wait cycle adds one.
REQ-019 dreq_size = {1'b0, msize}; dreq_addr = latched addr unmodified.
REQ-020 Store strobe: byte 0x01, half 0x03, word 0x0F, double 0xFF, shifted left by addr[2:0]; load strobe 0x00.
REQ-021 dreq_data = wdata shifted left by 8*addr[2:0], bits beyond 64 dropped.
REQ-022 rdata = dresp_data shifted right by 8*addr[2:0], truncated to access size, sign- or zero-extended per sign_ext; stores give rdata=0.
REQ-023 rdata captured on the data_ok edge and held until the next load completes.

Reset
REQ-024 resetn low immediately forces IDLE and dreq_valid=0, stall=0, done=0, rdata=0, misalign=0, dreq_* fields=0.
REQ-025 Reset during REQ or WAIT abandons the access; a data_ok arriving after reset release is ignored.

Configuration
REQ-026 Macro MEM_MISALIGN_CHECK_EN defined: an op with addr not aligned to its size skips REQ/WAIT, goes IDLE -> DONE, asserts misalign with done, issues no bus request, rdata=0.
REQ-027 Macro undefined: no alignment check, misalign port absent, misaligned ops issued to the bus as normal.

Verification
REQ-028 Load double, addr 0x80000008, addr_ok&data_ok first REQ cycle, data 0x1122334455667788 -> done in cycle 2, rdata 0x1122334455667788.
REQ-029 Load byte signed, addr 0x80000003, data 0x00000000_80FF0000 -> strobe 0x00, rdata 0xFFFFFFFFFFFFFF80; same with sign_ext=0 -> 0x80.
REQ-030 Store half, addr 0x80000006, wdata 0xBEEF -> strobe 0xC0, dreq_data 0xBEEF000000000000, fields stable across 3 addr_ok-low cycles.
REQ-031 addr_ok in REQ, data_ok 4 cycles later -> dreq_valid=0 in WAIT, stall=1 throughout, done single cycle after data_ok.
REQ-032 resetn low in WAIT, late data_ok after release -> state IDLE, done never asserted, rdata=0.
REQ-033 With MEM_MISALIGN_CHECK_EN: load word addr 0x80000002 -> no dreq_valid, done and misalign high in cycle 1.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: issues one data-bus request per load/store and
// aligns/extends the load result.
// Optional feature: define MEM_MISALIGN_CHECK_EN to complete misaligned ops
// locally (no bus request) and flag them on the misalign output.
module mem_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  msize,
  input  logic        sign_ext,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} stateT;

  stateT       state, stateNext;
  logic        memOp;
  logic        misNew;
  logic        capture;
  logic [7:0]  strobeBase;
  logic [7:0]  strobeNew;
  logic [63:0] dataNew;
  logic [63:0] shifted;
  logic [63:0] loadResult;

  logic [63:0] addrReg;
  logic [1:0]  sizeReg;
  logic [7:0]  strobeReg;
  logic [63:0] dataReg;
  logic        signReg;
  logic        loadReg;
  logic [63:0] rdataReg;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misReg;
`endif

  assign memOp = in_valid & (mem_read | mem_write);

  // Decode size into the byte-enable pattern and the alignment check
  always_comb begin
    strobeBase = 8'h00;
    misNew     = 1'b0;
    unique case (msize)
      2'd0: begin strobeBase = 8'h01; misNew = 1'b0;         end
      2'd1: begin strobeBase = 8'h03; misNew = addr[0];      end
      2'd2: begin strobeBase = 8'h0F; misNew = |addr[1:0];   end
      2'd3: begin strobeBase = 8'hFF; misNew = |addr[2:0];   end
      default: begin strobeBase = 8'h00; misNew = 1'b0;     end
    endcase
  end

  // Both read and write high counts as a store; loads carry no byte enables
  assign strobeNew = mem_write ? (strobeBase << addr[2:0]) : 8'h00;
  assign dataNew   = wdata << {addr[2:0], 3'b000};

  // Align the returned word to bit 0, truncate to size and extend
  always_comb begin
    shifted    = dresp_data >> {addrReg[2:0], 3'b000};
    loadResult = 64'd0;
    unique case (sizeReg)
      2'd0: loadResult = signReg ? {{56{shifted[7]}}, shifted[7:0]}   : {56'd0, shifted[7:0]};
      2'd1: loadResult = signReg ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      2'd2: loadResult = signReg ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      2'd3: loadResult = shifted;
      default: loadResult = 64'd0;
    endcase
    if (!loadReg) loadResult = 64'd0;
  end

  // Next-state logic; capture marks the edge on which response data is taken
  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    unique case (state)
      StIdle: begin
        if (memOp) begin
`ifdef MEM_MISALIGN_CHECK_EN
          stateNext = misNew ? StDone : StReq;
`else
          stateNext = StReq;
`endif
        end
      end
      StReq: begin
        if (dresp_addr_ok && dresp_data_ok) begin
          stateNext = StDone;
          capture   = 1'b1;
        end else if (dresp_addr_ok) begin
          stateNext = StWait;
        end
      end
      StWait: begin
        if (dresp_data_ok) begin
          stateNext = StDone;
          capture   = 1'b1;
        end
      end
      StDone:  stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= StIdle;
    else         state <= stateNext;
  end

  // Latch the request fields when an op is accepted from IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addrReg   <= 64'd0;
      sizeReg   <= 2'd0;
      strobeReg <= 8'h00;
      dataReg   <= 64'd0;
      signReg   <= 1'b0;
      loadReg   <= 1'b0;
    end else if (state == StIdle && memOp) begin
      addrReg   <= addr;
      sizeReg   <= msize;
      strobeReg <= strobeNew;
      dataReg   <= dataNew;
      signReg   <= sign_ext;
      loadReg   <= ~mem_write;
    end
  end

  // Load result register: held until the next access completes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdataReg <= 64'd0;
    end else if (capture) begin
      rdataReg <= loadResult;
`ifdef MEM_MISALIGN_CHECK_EN
    end else if (state == StIdle && memOp && misNew) begin
      rdataReg <= 64'd0;
`endif
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Remember whether the accepted op bypassed the bus
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      misReg <= 1'b0;
    else if (state == StIdle && memOp) misReg <= misNew;
  end

  assign misalign = (state == StDone) & misReg;
`endif

  assign dreq_valid  = (state == StReq);
  assign dreq_addr   = addrReg;
  assign dreq_size   = {1'b0, sizeReg};
  assign dreq_strobe = strobeReg;
  assign dreq_data   = dataReg;
  // Gated by resetn so stall drops immediately while reset is asserted
  assign stall       = resetn & memOp & (state != StDone);
  assign done        = (state == StDone);
  assign rdata       = rdataReg;

endmodule

// File: tb/tb_mem_access.sv
// Directed, table-driven bench for mem_access.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, mem_read, mem_write, sign_ext;
  logic [1:0]  msize;
  logic [63:0] addr, wdata;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stall, done;
  logic [63:0] rdata;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .msize        (msize),
    .sign_ext     (sign_ext),
    .addr         (addr),
    .wdata        (wdata),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .misalign     (misalign)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] resp;
    logic [7:0]  eStrb;
    logic [63:0] eData;
    logic [63:0] eRdata;
  } vecT;

  vecT vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setOp(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [63:0] a, input logic [63:0] wd);
    in_valid = v; mem_read = rd; mem_write = wr; msize = sz; sign_ext = sx;
    addr = a; wdata = wd;
  endtask

  task automatic setResp(input logic aok, input logic dok, input logic [63:0] d);
    dresp_addr_ok = aok; dresp_data_ok = dok; dresp_data = d;
  endtask

  // Single access with addr_ok&data_ok in the first REQ cycle
  task automatic runVec(input vecT v, input int idx);
    string n;
    n = $sformatf("v%0d", idx);
    @(negedge clk);
    setOp(1'b1, v.rd, v.wr, v.sz, v.sx, v.a, v.wd);
    setResp(1'b0, 1'b0, 64'd0);
    #1;
    chk({n, " c0 stall"}, {63'd0, stall}, 64'd1);
    chk({n, " c0 dreq_valid"}, {63'd0, dreq_valid}, 64'd0);
    @(negedge clk);
    setResp(1'b1, 1'b1, v.resp);
    #1;
    chk({n, " c1 dreq_valid"}, {63'd0, dreq_valid}, 64'd1);
    chk({n, " c1 addr"}, dreq_addr, v.a);
    chk({n, " c1 size"}, {61'd0, dreq_size}, {62'd0, v.sz});
    chk({n, " c1 strobe"}, {56'd0, dreq_strobe}, {56'd0, v.eStrb});
    chk({n, " c1 data"}, dreq_data, v.eData);
    chk({n, " c1 stall"}, {63'd0, stall}, 64'd1);
    chk({n, " c1 done"}, {63'd0, done}, 64'd0);
    @(negedge clk);
    setResp(1'b0, 1'b0, 64'd0);
    #1;
    chk({n, " c2 done"}, {63'd0, done}, 64'd1);
    chk({n, " c2 stall"}, {63'd0, stall}, 64'd0);
    chk({n, " c2 dreq_valid"}, {63'd0, dreq_valid}, 64'd0);
    chk({n, " c2 rdata"}, rdata, v.eRdata);
    @(negedge clk);
    setOp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    #1;
    chk({n, " c3 done"}, {63'd0, done}, 64'd0);
    chk({n, " c3 rdata held"}, rdata, v.eRdata);
  endtask

  initial begin
    //        rd    wr    sz    sx    addr                    wdata                   resp                    strobe  dreq_data               rdata
    vecs[0] = '{1'b1, 1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_0008, 64'd0,                  64'h1122_3344_5566_7788, 8'h00, 64'd0,                  64'h1122_3344_5566_7788};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 1'b1, 64'h0000_0000_8000_0003, 64'd0,                  64'h0000_0000_80FF_0000, 8'h00, 64'd0,                  64'hFFFF_FFFF_FFFF_FF80};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_0003, 64'd0,                  64'h0000_0000_80FF_0000, 8'h00, 64'd0,                  64'h0000_0000_0000_0080};
    vecs[3] = '{1'b0, 1'b1, 2'd1, 1'b0, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_BEEF, 64'h5555_5555_5555_5555, 8'hC0, 64'hBEEF_0000_0000_0000, 64'd0};
    vecs[4] = '{1'b0, 1'b1, 2'd2, 1'b0, 64'h0000_0000_1000_0004, 64'h0000_0000_DEAD_BEEF, 64'd0,                  8'hF0, 64'hDEAD_BEEF_0000_0000, 64'd0};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 1'b0, 64'h0000_0000_1000_0005, 64'h0000_0012_3456_78AB, 64'd0,                  8'h20, 64'h5678_AB00_0000_0000, 64'd0};
    vecs[6] = '{1'b1, 1'b0, 2'd1, 1'b1, 64'h0000_0000_2000_0002, 64'd0,                  64'h0000_0000_F00D_0000, 8'h00, 64'd0,                  64'hFFFF_FFFF_FFFF_F00D};
    vecs[7] = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h0000_0000_2000_0004, 64'd0,                  64'h8765_4321_0000_0000, 8'h00, 64'd0,                  64'h0000_0000_8765_4321};
    // read and write both high behaves as a store
    vecs[8] = '{1'b1, 1'b1, 2'd3, 1'b0, 64'h0000_0000_0000_0000, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0};

    resetn = 1'b0;
    setOp(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h1234, 64'h5678);
    setResp(1'b0, 1'b0, 64'd0);
    #1;
    chk("reset dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset rdata", rdata, 64'd0);
    chk("reset dreq_addr", dreq_addr, 64'd0);
    chk("reset dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    setOp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    resetn = 1'b1;

    // Non-memory instruction: no stall, no request
    @(negedge clk);
    setOp(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 64'h40, 64'd0);
    #1;
    chk("nonmem stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    #1;
    chk("nonmem dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("nonmem done", {63'd0, done}, 64'd0);
    // Memory op without in_valid: no stall
    setOp(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h40, 64'd0);
    #1;
    chk("invalid stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    #1;
    chk("invalid dreq_valid", {63'd0, dreq_valid}, 64'd0);
    setOp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);

    for (int i = 0; i < 9; i++) runVec(vecs[i], i);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned word load completes locally in cycle 1
    @(negedge clk);
    setOp(1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 64'h0000_0000_8000_0002, 64'd0);
    setResp(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    chk("mis c0 stall", {63'd0, stall}, 64'd1);
    @(negedge clk);
    #1;
    chk("mis c1 dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("mis c1 done", {63'd0, done}, 64'd1);
    chk("mis c1 misalign", {63'd0, misalign}, 64'd1);
    chk("mis c1 rdata", rdata, 64'd0);
    chk("mis c1 stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    setOp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    setResp(1'b0, 1'b0, 64'd0);
    #1;
    chk("mis c2 done", {63'd0, done}, 64'd0);
    chk("mis c2 misalign", {63'd0, misalign}, 64'd0);
    chk("mis c2 dreq_valid", {63'd0, dreq_valid}, 64'd0);
    // Aligned op still sees misalign low
    runVec(vecs[0], 90);
    chk("aligned misalign", {63'd0, misalign}, 64'd0);
`else
    // Without the check, a misaligned word load goes to the bus normally
    begin
      vecT mv;
      mv = '{1'b1, 1'b0, 2'd2, 1'b1, 64'h0000_0000_8000_0001, 64'd0,
             64'h0000_00AA_BBCC_DD00, 8'h00, 64'd0, 64'hFFFF_FFFF_AABB_CCDD};
      runVec(mv, 90);
    end
`endif

    // Store half held in REQ for 3 cycles without addr_ok; data_ok alone is ignored
    @(negedge clk);
    setOp(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_BEEF);
    setResp(1'b0, 1'b0, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      setResp(1'b0, (c == 1), 64'h1111_2222_3333_4444);
      #1;
      chk($sformatf("hold%0d dreq_valid", c), {63'd0, dreq_valid}, 64'd1);
      chk($sformatf("hold%0d addr", c), dreq_addr, 64'h0000_0000_8000_0006);
      chk($sformatf("hold%0d strobe", c), {56'd0, dreq_strobe}, 64'h0000_0000_0000_00C0);
      chk($sformatf("hold%0d data", c), dreq_data, 64'hBEEF_0000_0000_0000);
      chk($sformatf("hold%0d size", c), {61'd0, dreq_size}, 64'd1);
      chk($sformatf("hold%0d stall", c), {63'd0, stall}, 64'd1);
      chk($sformatf("hold%0d done", c), {63'd0, done}, 64'd0);
    end
    @(negedge clk);
    setResp(1'b1, 1'b1, 64'd0);
    #1;
    chk("hold3 dreq_valid", {63'd0, dreq_valid}, 64'd1);
    @(negedge clk);
    setResp(1'b0, 1'b0, 64'd0);
    #1;
    chk("hold done", {63'd0, done}, 64'd1);
    chk("hold rdata", rdata, 64'd0);
    @(negedge clk);
    setOp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("hold idle done", {63'd0, done}, 64'd0);

    // addr_ok in REQ, data_ok four cycles later
    @(negedge clk);
    setOp(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_0010, 64'd0);
    @(negedge clk);
    setResp(1'b1, 1'b0, 64'd0);
    #1;
    chk("wait req dreq_valid", {63'd0, dreq_valid}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      setResp(1'b0, (c == 3), 64'hCAFE_F00D_1234_5678);
      #1;
      chk($sformatf("wait%0d dreq_valid", c), {63'd0, dreq_valid}, 64'd0);
      chk($sformatf("wait%0d stall", c), {63'd0, stall}, 64'd1);
      chk($sformatf("wait%0d done", c), {63'd0, done}, 64'd0);
    end
    @(negedge clk);
    setResp(1'b0, 1'b0, 64'd0);
    #1;
    chk("wait done", {63'd0, done}, 64'd1);
    chk("wait done stall", {63'd0, stall}, 64'd0);
    chk("wait rdata", rdata, 64'hCAFE_F00D_1234_5678);
    @(negedge clk);
    setOp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("wait done single", {63'd0, done}, 64'd0);

    // Reset in WAIT, then a stale data_ok after release
    @(negedge clk);
    setOp(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_0018, 64'd0);
    @(negedge clk);
    setResp(1'b1, 1'b0, 64'd0);
    @(negedge clk);
    setResp(1'b0, 1'b0, 64'd0);
    #1;
    chk("rst pre dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst pre stall", {63'd0, stall}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst stall", {63'd0, stall}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst rdata", rdata, 64'd0);
    chk("rst dreq_addr", dreq_addr, 64'd0);
    @(negedge clk);
    setOp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    resetn = 1'b1;
    setResp(1'b0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("late%0d done", c), {63'd0, done}, 64'd0);
      chk($sformatf("late%0d dreq_valid", c), {63'd0, dreq_valid}, 64'd0);
      chk($sformatf("late%0d rdata", c), rdata, 64'd0);
    end
    setResp(1'b0, 1'b0, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
